// File: rtl/uart_pkg.sv
// Shared types and timing constants for the UART command path.
package uart_pkg;

    localparam int BAUD_CYCLES     = 2604;
    localparam int BYTE_CYCLES     = 10 * BAUD_CYCLES;
    localparam int TIMEOUT_DEFAULT = 2 * BYTE_CYCLES;

    typedef enum logic [1:0] {
        WAIT_HI   = 2'd0,
        WAIT_LO   = 2'd1,
        CMD_VALID = 2'd2
    } cmd_asm_state_t;

endpackage

// File: rtl/uart_cmd_assembler_if.sv
// Byte-in / command-out handshake bundle between UART receiver, assembler and command processor.
interface uart_cmd_assembler_if;

    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        clr_rx_rdy;
    logic        clr_cmd_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        busy;
    logic        frame_err;

    modport master (
        output rx_data, rx_rdy, clr_cmd_rdy,
        input  clr_rx_rdy, cmd, cmd_rdy, busy, frame_err
    );

    modport slave (
        input  rx_data, rx_rdy, clr_cmd_rdy,
        output clr_rx_rdy, cmd, cmd_rdy, busy, frame_err
    );

endinterface

// File: rtl/uart_cmd_assembler.sv
// Pairs received bytes into 16-bit commands {high, low}; an inter-byte timeout
// drops an orphaned high byte so the stream resynchronises.
module uart_cmd_assembler
    import uart_pkg::*;
#(
    parameter  int TIMEOUT = TIMEOUT_DEFAULT,
    localparam int TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_cmd_assembler_if.slave  bus
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    cmd_asm_state_t  state_r;
    logic [7:0]      hi_byte_r;
    logic [TO_W-1:0] timer_r;
    logic [15:0]     cmd_r;
    logic            cmd_rdy_r;
    logic            clr_rx_rdy_r;
    logic            busy_r;
    logic            frame_err_r;

    logic            accept_s;
    logic            timeout_s;

    // Byte acceptance: the clr_rx_rdy guard stops a byte being taken twice while rdy decays.
    always_comb begin
        accept_s  = 1'b0;
        timeout_s = 1'b0;
        if ((state_r == WAIT_HI) || (state_r == WAIT_LO)) begin
            accept_s = bus.rx_rdy & ~clr_rx_rdy_r;
        end else begin
            accept_s = 1'b0;
        end
        if (state_r == WAIT_LO) begin
            timeout_s = (timer_r == TO_LAST);
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Assembler FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= WAIT_HI;
            hi_byte_r    <= 8'h00;
            timer_r      <= '0;
            cmd_r        <= 16'h0000;
            cmd_rdy_r    <= 1'b0;
            clr_rx_rdy_r <= 1'b0;
            busy_r       <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            clr_rx_rdy_r <= accept_s;
            frame_err_r  <= 1'b0;
            case (state_r)
                WAIT_HI: begin
                    if (accept_s) begin
                        hi_byte_r <= bus.rx_data;
                        timer_r   <= '0;
                        busy_r    <= 1'b1;
                        state_r   <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    // Acceptance outranks a timeout landing in the same cycle.
                    if (accept_s) begin
                        cmd_r     <= {hi_byte_r, bus.rx_data};
                        cmd_rdy_r <= 1'b1;
                        busy_r    <= 1'b0;
                        state_r   <= CMD_VALID;
                    end else if (timeout_s) begin
                        hi_byte_r   <= 8'h00;
                        timer_r     <= '0;
                        busy_r      <= 1'b0;
                        frame_err_r <= 1'b1;
                        state_r     <= WAIT_HI;
                    end else begin
                        timer_r <= timer_r + TO_ONE;
                    end
                end
                CMD_VALID: begin
                    if (bus.clr_cmd_rdy) begin
                        cmd_rdy_r <= 1'b0;
                        state_r   <= WAIT_HI;
                    end
                end
                default: begin
                    timer_r   <= '0;
                    cmd_rdy_r <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= WAIT_HI;
                end
            endcase
        end
    end

    assign bus.cmd        = cmd_r;
    assign bus.cmd_rdy    = cmd_rdy_r;
    assign bus.clr_rx_rdy = clr_rx_rdy_r;
    assign bus.busy       = busy_r;
    assign bus.frame_err  = frame_err_r;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Self-checking bench for uart_cmd_assembler: receiver model, expected-command
// scoreboard queue and one task per scenario.
module tb_uart_cmd_assembler;

    localparam int TIMEOUT = 40;

    logic clk;
    logic rst;
    uart_cmd_assembler_if bus ();

    uart_cmd_assembler #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          clr_cnt = 0;
    int          fe_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_cmd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.clr_rx_rdy === 1'b1) clr_cnt++;
        if (bus.frame_err === 1'b1) fe_cnt++;
    end

    // Receiver model: raise rdy, wait for clr pulse, drop rdy one cycle after it.
    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        bus.rx_data = b;
        bus.rx_rdy  = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            @(posedge clk); #1;
            if (bus.clr_rx_rdy === 1'b1) got = 1'b1;
        end
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL accept: byte %h got no clr_rx_rdy within 20 cycles", b);
        end
        @(posedge clk); #1;
        bus.rx_rdy = 1'b0;
        n_vec++;
        if (bus.clr_rx_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL clr_width: clr_rx_rdy=%b required 0 one cycle after pulse", bus.clr_rx_rdy);
        end
    endtask

    task automatic ack_cmd();
        bus.clr_cmd_rdy = 1'b1;
        @(posedge clk); #1;
        bus.clr_cmd_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.rx_data = 8'h00;
        bus.rx_rdy = 1'b0;
        bus.clr_cmd_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (bus.cmd !== 16'h0000) begin n_err++; $display("FAIL rst_cmd: %h required 0000", bus.cmd); end
        n_vec++; if (bus.cmd_rdy !== 1'b0) begin n_err++; $display("FAIL rst_cmd_rdy: %b required 0", bus.cmd_rdy); end
        n_vec++; if (bus.clr_rx_rdy !== 1'b0) begin n_err++; $display("FAIL rst_clr: %b required 0", bus.clr_rx_rdy); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: %b required 0", bus.busy); end
        n_vec++; if (bus.frame_err !== 1'b0) begin n_err++; $display("FAIL rst_ferr: %b required 0", bus.frame_err); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_normal();
        int c0;
        c0 = clr_cnt;
        send_byte(8'hA5);
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL normal_busy: %b required 1", bus.busy); end
        n_vec++; if (bus.cmd_rdy !== 1'b0) begin n_err++; $display("FAIL normal_early: cmd_rdy=%b required 0", bus.cmd_rdy); end
        exp_q.push_back(16'hA53C);
        bus.rx_data = 8'h3C;
        bus.rx_rdy = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (bus.clr_rx_rdy !== 1'b1) begin n_err++; $display("FAIL normal_clr: %b required 1", bus.clr_rx_rdy); end
        n_vec++; if (bus.cmd_rdy !== 1'b1) begin n_err++; $display("FAIL normal_latency: cmd_rdy=%b required 1", bus.cmd_rdy); end
        exp_cmd = exp_q.pop_front();
        n_vec++; if (bus.cmd !== exp_cmd) begin n_err++; $display("FAIL normal_cmd: %h required %h", bus.cmd, exp_cmd); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL normal_busy_fall: %b required 0", bus.busy); end
        @(posedge clk); #1;
        bus.rx_rdy = 1'b0;
        n_vec++; if (clr_cnt - c0 !== 2) begin n_err++; $display("FAIL normal_pulses: %0d required 2", clr_cnt - c0); end
        ack_cmd();
        n_vec++; if (bus.cmd_rdy !== 1'b0) begin n_err++; $display("FAIL normal_ack: cmd_rdy=%b required 0", bus.cmd_rdy); end
        n_vec++; if (bus.cmd !== 16'hA53C) begin n_err++; $display("FAIL normal_hold: %h required a53c", bus.cmd); end
    endtask

    task automatic test_back_pressure();
        send_byte(8'h12);
        exp_q.push_back(16'h1234);
        send_byte(8'h34);
        exp_cmd = exp_q.pop_front();
        n_vec++; if (bus.cmd_rdy !== 1'b1 || bus.cmd !== exp_cmd) begin
            n_err++; $display("FAIL bp_cmd: rdy=%b cmd=%h required 1 %h", bus.cmd_rdy, bus.cmd, exp_cmd);
        end
        bus.rx_data = 8'h56;
        bus.rx_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_vec++; if (bus.clr_rx_rdy !== 1'b0 || bus.cmd !== 16'h1234 || bus.cmd_rdy !== 1'b1) begin
                n_err++; $display("FAIL bp_hold: clr=%b cmd=%h rdy=%b required 0 1234 1", bus.clr_rx_rdy, bus.cmd, bus.cmd_rdy);
            end
        end
        ack_cmd();
        n_vec++; if (bus.clr_rx_rdy !== 1'b0 || bus.cmd_rdy !== 1'b0) begin
            n_err++; $display("FAIL bp_same_cycle: clr=%b rdy=%b required 0 0", bus.clr_rx_rdy, bus.cmd_rdy);
        end
        @(posedge clk); #1;
        n_vec++; if (bus.clr_rx_rdy !== 1'b1 || bus.busy !== 1'b1) begin
            n_err++; $display("FAIL bp_release: clr=%b busy=%b required 1 1", bus.clr_rx_rdy, bus.busy);
        end
        @(posedge clk); #1;
        bus.rx_rdy = 1'b0;
        exp_q.push_back(16'h5678);
        send_byte(8'h78);
        exp_cmd = exp_q.pop_front();
        n_vec++; if (bus.cmd_rdy !== 1'b1 || bus.cmd !== exp_cmd) begin
            n_err++; $display("FAIL bp_next: rdy=%b cmd=%h required 1 %h", bus.cmd_rdy, bus.cmd, exp_cmd);
        end
        ack_cmd();
    endtask

    task automatic test_timeout();
        int f0;
        int n;
        f0 = fe_cnt;
        send_byte(8'hFF);
        n = 1;
        while (n < TIMEOUT + 10 && bus.busy === 1'b1) begin
            @(posedge clk); #1;
            n++;
        end
        n_vec++; if (n !== TIMEOUT || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL to_cycle: busy=%b after %0d cycles required 0 after %0d", bus.busy, n, TIMEOUT);
        end
        n_vec++; if (bus.frame_err !== 1'b1) begin n_err++; $display("FAIL to_ferr: %b required 1", bus.frame_err); end
        @(posedge clk); #1;
        n_vec++; if (bus.frame_err !== 1'b0) begin n_err++; $display("FAIL to_ferr_width: %b required 0", bus.frame_err); end
        send_byte(8'h01);
        exp_q.push_back(16'h0102);
        send_byte(8'h02);
        exp_cmd = exp_q.pop_front();
        n_vec++; if (bus.cmd_rdy !== 1'b1 || bus.cmd !== exp_cmd) begin
            n_err++; $display("FAIL to_resync: rdy=%b cmd=%h required 1 %h", bus.cmd_rdy, bus.cmd, exp_cmd);
        end
        n_vec++; if (fe_cnt - f0 !== 1) begin n_err++; $display("FAIL to_count: %0d frame_err pulses required 1", fe_cnt - f0); end
        ack_cmd();
    endtask

    task automatic test_boundary();
        int f0;
        f0 = fe_cnt;
        send_byte(8'hC3);
        repeat (TIMEOUT - 2) begin
            @(posedge clk); #1;
        end
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL bd_busy: %b required 1", bus.busy); end
        exp_q.push_back(16'hC35A);
        send_byte(8'h5A);
        exp_cmd = exp_q.pop_front();
        n_vec++; if (bus.cmd_rdy !== 1'b1 || bus.cmd !== exp_cmd) begin
            n_err++; $display("FAIL bd_cmd: rdy=%b cmd=%h required 1 %h", bus.cmd_rdy, bus.cmd, exp_cmd);
        end
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (fe_cnt - f0 !== 0) begin n_err++; $display("FAIL bd_ferr: %0d pulses required 0", fe_cnt - f0); end
        ack_cmd();
    endtask

    task automatic test_reset_mid();
        send_byte(8'hAA);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++; if (bus.cmd !== 16'h0000 || bus.cmd_rdy !== 1'b0 || bus.busy !== 1'b0 ||
                     bus.clr_rx_rdy !== 1'b0 || bus.frame_err !== 1'b0) begin
            n_err++; $display("FAIL rm_outputs: cmd=%h rdy=%b busy=%b clr=%b ferr=%b required all 0",
                              bus.cmd, bus.cmd_rdy, bus.busy, bus.clr_rx_rdy, bus.frame_err);
        end
        send_byte(8'h11);
        exp_q.push_back(16'h1122);
        send_byte(8'h22);
        exp_cmd = exp_q.pop_front();
        n_vec++; if (bus.cmd_rdy !== 1'b1 || bus.cmd !== exp_cmd) begin
            n_err++; $display("FAIL rm_cmd: rdy=%b cmd=%h required 1 %h", bus.cmd_rdy, bus.cmd, exp_cmd);
        end
        ack_cmd();
    endtask

    task automatic test_stuck_rdy();
        int c0;
        c0 = clr_cnt;
        bus.rx_data = 8'h77;
        bus.rx_rdy = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (bus.clr_rx_rdy !== 1'b1) begin n_err++; $display("FAIL st_first: clr=%b required 1", bus.clr_rx_rdy); end
        @(posedge clk); #1;
        n_vec++; if (bus.clr_rx_rdy !== 1'b0 || bus.cmd_rdy !== 1'b0 || bus.busy !== 1'b1) begin
            n_err++; $display("FAIL st_guard: clr=%b rdy=%b busy=%b required 0 0 1", bus.clr_rx_rdy, bus.cmd_rdy, bus.busy);
        end
        bus.rx_rdy = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (bus.clr_rx_rdy !== 1'b0) begin n_err++; $display("FAIL st_third: clr=%b required 0", bus.clr_rx_rdy); end
        exp_q.push_back(16'h7788);
        send_byte(8'h88);
        exp_cmd = exp_q.pop_front();
        n_vec++; if (bus.cmd_rdy !== 1'b1 || bus.cmd !== exp_cmd) begin
            n_err++; $display("FAIL st_cmd: rdy=%b cmd=%h required 1 %h", bus.cmd_rdy, bus.cmd, exp_cmd);
        end
        n_vec++; if (clr_cnt - c0 !== 2) begin n_err++; $display("FAIL st_pulses: %0d required 2", clr_cnt - c0); end
        ack_cmd();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_back_pressure();
        test_timeout();
        test_boundary();
        test_reset_mid();
        test_stuck_rdy();
        n_vec++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL sb_leftover: %0d entries required 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_cmd_assembler.md
Name: uart_cmd_assembler

Overview:
- Sits directly downstream of the UART receiver.
- Consumes received bytes through the receiver's rdy/clr_rdy handshake and pairs them into 16-bit commands: high byte first, then low byte.
- Presents each command to the command processor with a cmd_rdy/clr_cmd_rdy handshake.
- An inter-byte timeout discards an orphaned high byte, so the stream resynchronises after a dropped byte.

Parameters:
- TIMEOUT, 52080, clock cycles allowed between high-byte acceptance and low-byte arrival (about two byte times at 2604 clk/bit).
- TO_W, $clog2(TIMEOUT+1), width of the timeout counter (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- rx_data  input  8  byte from the UART receiver.
- rx_rdy  input  1  receiver byte-valid (level; stays high until the receiver sees clr_rx_rdy).
- clr_rx_rdy  output  1  registered one-cycle pulse that consumes the current byte.
- clr_cmd_rdy  input  1  consumer acknowledge of cmd.
- cmd  output  16  assembled command {high, low}.
- cmd_rdy  output  1  cmd valid; level, held until acknowledged.
- busy  output  1  high while a high byte is held awaiting its low byte.
- frame_err  output  1  one-cycle pulse when a high byte is discarded on timeout.

Behaviour:
- Reset (rst=1 at posedge):
  - state=WAIT_HI; cmd=16'h0000; hi_byte=8'h00; timer=0.
  - cmd_rdy, clr_rx_rdy, busy and frame_err are all 0.
  - Reset wins over every other input; a partial command is discarded.
- Byte acceptance: a byte is accepted in a cycle when rx_rdy=1 AND clr_rx_rdy=0 AND state is WAIT_HI or WAIT_LO.
  - The clr_rx_rdy=0 guard prevents double consumption, because the receiver drops rdy one cycle after the pulse.
- On acceptance, clr_rx_rdy=1 in the following cycle only.
- WAIT_HI:
  - On acceptance: hi_byte<=rx_data, timer<=0, go to WAIT_LO.
  - clr_cmd_rdy is ignored.
- WAIT_LO:
  - busy=1; timer increments every cycle.
  - On acceptance: cmd<={hi_byte,rx_data}, cmd_rdy<=1, go to CMD_VALID. cmd and cmd_rdy become visible together one cycle after acceptance.
  - Otherwise, if timer==TIMEOUT-1: go to WAIT_HI and pulse frame_err for one cycle; hi_byte is dropped.
  - If acceptance and timeout occur in the same cycle, acceptance wins and there is no frame_err.
- CMD_VALID:
  - cmd_rdy=1 and cmd is stable; no bytes are accepted. Back-pressure is left in the receiver and rx_rdy is held.
  - On clr_cmd_rdy=1: cmd_rdy<=0, go to WAIT_HI. A pending rx_rdy is accepted from the next cycle onward, never in the same cycle.
- cmd holds its last value after cmd_rdy drops, until the next command completes.
- Command latency: from low-byte acceptance to cmd_rdy=1 is exactly 1 cycle.
- Timer saturation: the timer is only meaningful in WAIT_LO; it is cleared on entry and never wraps, because timeout triggers at TIMEOUT-1.
- State encoding: enum {WAIT_HI, WAIT_LO, CMD_VALID}; illegal or default state goes to WAIT_HI.

Decomposition:
- Shared package uart_pkg holds:
  - cmd_asm_state_t enum.
  - localparam BAUD_CYCLES=2604 and BYTE_CYCLES=10*BAUD_CYCLES.
  - TIMEOUT default expressed as 2*BYTE_CYCLES.
- No sub-module. The timeout counter is inline; it is small enough that a separate counter module adds nothing.

Test Plan:
- Normal command: send 8'hA5 then 8'h3C → after the second clr_rx_rdy pulse, cmd=16'hA53C and cmd_rdy=1 on the next cycle; exactly two one-cycle clr_rx_rdy pulses.
- Back-pressure:
  - Stimulus: complete 16'h1234, hold clr_cmd_rdy=0, present 8'h56 with rx_rdy=1.
  - Response: no clr_rx_rdy while cmd_rdy=1 and cmd stays 16'h1234. Assert clr_cmd_rdy → the 8'h56 byte is accepted the cycle after.
- Timeout resync:
  - Stimulus: send 8'hFF, wait TIMEOUT cycles, then send 8'h01, 8'h02.
  - Response: frame_err pulses once and busy falls; the result is cmd=16'h0102, not 16'hFF01.
- Boundary: the low byte arrives in the exact cycle timer==TIMEOUT-1 → command completes and frame_err stays 0.
- Reset mid-command: assert rst in WAIT_LO after high byte 8'hAA, then send 8'h11, 8'h22 → cmd=16'h1122; all outputs 0 on the cycle after rst.
- Stuck-rdy guard: hold rx_rdy=1 for 3 cycles with the same byte → exactly one acceptance and one clr_rx_rdy pulse per receiver rdy assertion (the model drops rdy one cycle after clr).
